// File: rtl/axis_arb_pkg.sv
// Shared types and widths for the frame-granular AXI4-Stream arbiter.
package axis_arb_pkg;

  localparam int unsigned AXIS_DATA_WIDTH = 64;
  localparam int unsigned AXIS_KEEP_WIDTH = 8;

  typedef enum logic [0:0] {
    IDLE,
    LOCKED
  } arb_state_t;

endpackage

// File: rtl/rr_picker.sv
// Round-robin picker: first set bit of req at or after ptr, searching upward with wrap-around.
module rr_picker #(
  parameter int unsigned NUM_PORTS = 2
) (
  input  logic [NUM_PORTS-1:0]         req,
  input  logic [$clog2(NUM_PORTS)-1:0] ptr,
  output logic                         found,
  output logic [$clog2(NUM_PORTS)-1:0] index
);

  localparam int unsigned PtrW = $clog2(NUM_PORTS);
  localparam logic [PtrW:0] PortsW = (PtrW + 1)'(NUM_PORTS);

  logic [2*NUM_PORTS-1:0] dbl;
  logic [NUM_PORTS-1:0]   rot;
  logic [PtrW-1:0]        off;
  logic [PtrW:0]          sum;

  always_comb begin
    dbl   = {req, req};
    // Doubling the vector turns the wrap-around search into a plain shift.
    rot   = NUM_PORTS'(dbl >> ptr);
    found = |req;
    off   = '0;
    for (int i = NUM_PORTS - 1; i >= 0; i--) begin
      if (rot[i]) begin
        off = PtrW'(i);
      end
    end
    sum = {1'b0, ptr} + {1'b0, off};
    if (sum >= PortsW) begin
      sum = sum - PortsW;
    end
    index = sum[PtrW-1:0];
  end

endmodule

// File: rtl/axis_frame_arbiter.sv
// Frame-granular round-robin arbiter sharing one registered 64-bit AXI4-Stream output.
module axis_frame_arbiter
  import axis_arb_pkg::*;
#(
  parameter int unsigned NUM_PORTS = 2,
  parameter int unsigned ID_WIDTH  = $clog2(NUM_PORTS)
) (
  input  logic                                         clock,
  input  logic                                         aresetn,
  input  logic [NUM_PORTS-1:0][AXIS_DATA_WIDTH-1:0]    saxis_tdata,
  input  logic [NUM_PORTS-1:0][AXIS_KEEP_WIDTH-1:0]    saxis_tkeep,
  input  logic [NUM_PORTS-1:0]                         saxis_tuser,
  input  logic [NUM_PORTS-1:0]                         saxis_tlast,
  input  logic [NUM_PORTS-1:0]                         saxis_tvalid,
  output logic [NUM_PORTS-1:0]                         saxis_tready,
  output logic [AXIS_DATA_WIDTH-1:0]                   maxis_tdata,
  output logic [AXIS_KEEP_WIDTH-1:0]                   maxis_tkeep,
  output logic                                         maxis_tuser,
  output logic                                         maxis_tlast,
  output logic [ID_WIDTH-1:0]                          maxis_tid,
  output logic                                         maxis_tvalid,
  input  logic                                         maxis_tready,
  output logic                                         busy
);

  localparam int unsigned PtrW = $clog2(NUM_PORTS);

  arb_state_t      state_q, state_d;
  logic [PtrW-1:0] grant_q, grant_d;
  logic [PtrW-1:0] rr_ptr_q, rr_ptr_d;
  logic [PtrW-1:0] pick_index;
  logic            pick_found;
  logic            out_ready;
  logic            in_fire;

  rr_picker #(
    .NUM_PORTS(NUM_PORTS)
  ) u_picker (
    .req  (saxis_tvalid),
    .ptr  (rr_ptr_q),
    .found(pick_found),
    .index(pick_index)
  );

  always_comb begin
    state_d      = state_q;
    grant_d      = grant_q;
    rr_ptr_d     = rr_ptr_q;
    saxis_tready = '0;
    out_ready    = !maxis_tvalid || maxis_tready;
    in_fire      = 1'b0;
    case (state_q)
      IDLE: begin
        if (pick_found) begin
          grant_d = pick_index;
          state_d = LOCKED;
        end
      end
      LOCKED: begin
        saxis_tready[grant_q] = out_ready;
        in_fire               = out_ready && saxis_tvalid[grant_q];
        if (in_fire && saxis_tlast[grant_q]) begin
          state_d  = IDLE;
          rr_ptr_d = (grant_q == PtrW'(NUM_PORTS - 1)) ? '0 : grant_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge aresetn) begin
    if (!aresetn) begin
      state_q      <= IDLE;
      grant_q      <= '0;
      rr_ptr_q     <= '0;
      maxis_tdata  <= '0;
      maxis_tkeep  <= '0;
      maxis_tuser  <= 1'b0;
      maxis_tlast  <= 1'b0;
      maxis_tid    <= '0;
      maxis_tvalid <= 1'b0;
    end else begin
      state_q  <= state_d;
      grant_q  <= grant_d;
      rr_ptr_q <= rr_ptr_d;
      // A loading beat takes precedence over a drain in the same cycle.
      if (in_fire) begin
        maxis_tdata  <= saxis_tdata[grant_q];
        maxis_tkeep  <= saxis_tkeep[grant_q];
        maxis_tuser  <= saxis_tuser[grant_q];
        maxis_tlast  <= saxis_tlast[grant_q];
        maxis_tid    <= ID_WIDTH'(grant_q);
        maxis_tvalid <= 1'b1;
      end else if (maxis_tready) begin
        maxis_tvalid <= 1'b0;
      end
    end
  end

  assign busy = (state_q == LOCKED);

endmodule
